// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - simplified AXI aw/w/ar/r channel bundle, PORTS masters wide
interface sdram_port_arbiter_if #(
    parameter int PORTS      = 1,
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 16
);
    logic [PORTS*ADDR_WIDTH-1:0] awaddr;
    logic [PORTS-1:0]            awvalid;
    logic [PORTS-1:0]            awready;
    logic [PORTS*DATA_WIDTH-1:0] wdata;
    logic [PORTS-1:0]            wvalid;
    logic [PORTS-1:0]            wready;
    logic [PORTS*ADDR_WIDTH-1:0] araddr;
    logic [PORTS-1:0]            arvalid;
    logic [PORTS-1:0]            arready;
    logic [DATA_WIDTH-1:0]       rdata;
    logic [PORTS-1:0]            rvalid;
    logic [PORTS-1:0]            rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, araddr, arvalid, rready,
        input  awready, wready, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, araddr, arvalid, rready,
        output awready, wready, arready, rdata, rvalid
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port arbiter in front of the SDRAM controller; SDRAM_ARB_ROUND_ROBIN_EN selects round-robin
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    sdram_port_arbiter_if.slave  s,
    sdram_port_arbiter_if.master m
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              wr_req;
    logic [1:0]              rd_req;
    logic [1:0]              req;
    logic                    win;
    logic                    win_wr;
    logic                    grant;
    logic                    owner_q;
    logic                    kind_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   rbuf_q;

    assign wr_req = s.awvalid & s.wvalid;
    assign rd_req = s.arvalid;
    assign req    = wr_req | rd_req;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic ptr_q;

    // ptr_q holds the last granted port; a contested cycle goes to the other one
    assign win = (req[0] & req[1]) ? ~ptr_q : req[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= 1'b1;
        end else if (grant) begin
            ptr_q <= win;
        end
    end
`else
    assign win = ~req[0];
`endif

    assign win_wr = win ? wr_req[1] : wr_req[0];
    // resetn gates the grant so upstream readies stay low while reset is held
    assign grant  = resetn & (state == IDLE) & (|req);

    assign m.awaddr = addr_q;
    assign m.araddr = addr_q;
    assign m.wdata  = data_q;
    assign s.rdata  = rbuf_q;

    always_comb begin
        state_nxt = state;
        s.awready = '0;
        s.wready  = '0;
        s.arready = '0;
        s.rvalid  = '0;
        m.awvalid = '0;
        m.wvalid  = '0;
        m.arvalid = '0;
        m.rready  = '0;
        case (state)
            IDLE: begin
                if (grant) begin
                    if (win_wr) begin
                        s.awready[win] = 1'b1;
                        s.wready[win]  = 1'b1;
                    end else begin
                        s.arready[win] = 1'b1;
                    end
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (kind_q) begin
                    m.awvalid = 1'b1;
                    m.wvalid  = 1'b1;
                    if (m.awready[0] && m.wready[0]) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    m.arvalid = 1'b1;
                    if (m.arready[0]) begin
                        state_nxt = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                m.rready = 1'b1;
                if (m.rvalid[0]) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                s.rvalid[owner_q] = 1'b1;
                if (s.rready[owner_q]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            owner_q <= 1'b0;
            kind_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_q <= win;
                kind_q  <= win_wr;
                if (win_wr) begin
                    addr_q <= win ? s.awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s.awaddr[ADDR_WIDTH-1:0];
                    data_q <= win ? s.wdata[2*DATA_WIDTH-1:DATA_WIDTH] : s.wdata[DATA_WIDTH-1:0];
                end else begin
                    addr_q <= win ? s.araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s.araddr[ADDR_WIDTH-1:0];
                end
            end
            // read data is only taken while a read is actually outstanding
            if (state == WAIT_R && m.rvalid[0]) begin
                rbuf_q <= m.rdata;
            end
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter with randomized masters and controller
module tb_sdram_port_arbiter;
    localparam int AW = 25;
    localparam int DW = 16;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } dn_item_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_port_arbiter_if #(.PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) up ();
    sdram_port_arbiter_if #(.PORTS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn ();

    sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .s      (up.slave),
        .m      (dn.master)
    );

    // reference model state
    bit            busy = 1'b0;
    bit            last_grant = 1'b1;
    bit [1:0]      wr_pend = '0;
    bit [1:0]      rd_pend = '0;
    logic [AW-1:0] wa [2];
    logic [DW-1:0] wd [2];
    logic [AW-1:0] ra [2];
    dn_item_t      dq [$];
    logic [DW-1:0] rq0 [$];
    logic [DW-1:0] rq1 [$];
    bit            grants [$];
    int            wr_hs_cyc = 0;

    // knobs
    bit          gen_en = 1'b0;
    bit          rd_only = 1'b0;
    int unsigned req_pct = 40;
    int unsigned rdy_pct = 100;
    int unsigned rready_pct = 100;
    bit          stray_en = 1'b0;
    bit          ctrl_hold = 1'b0;
    bit          force_stray = 1'b0;
    int          aw_stall = 0;

    function automatic logic [DW-1:0] rhash(input logic [AW-1:0] a);
        return a[15:0] ^ {7'h0, a[24:16]} ^ 16'h3C5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s unexpected event (cycle %0d)", name, cyc);
    endtask

    task automatic drive();
        up.awvalid = wr_pend;
        up.wvalid  = wr_pend;
        up.arvalid = rd_pend;
        up.awaddr  = {wa[1], wa[0]};
        up.wdata   = {wd[1], wd[0]};
        up.araddr  = {ra[1], ra[0]};
    endtask

    task automatic observe();
        logic [1:0] e_aw;
        logic [1:0] e_ar;
        bit g, w, wk, r0, r1;
        e_aw = '0;
        e_ar = '0;
        g = 1'b0;
        w = 1'b0;
        wk = 1'b0;
        r0 = wr_pend[0] | rd_pend[0];
        r1 = wr_pend[1] | rd_pend[1];
        if (resetn && !busy && (r0 || r1)) begin
            g = 1'b1;
            if (r0 && r1) w = RR ? !last_grant : 1'b0;
            else w = r1;
            wk = wr_pend[w];
            if (wk) e_aw[w] = 1'b1;
            else e_ar[w] = 1'b1;
        end
        check("arb_awready", 64'(up.awready), 64'(e_aw));
        check("arb_wready", 64'(up.wready), 64'(e_aw));
        check("arb_arready", 64'(up.arready), 64'(e_ar));
        if (dn.awvalid[0] && dn.awready[0] && dn.wready[0]) busy = 1'b0;
        if ((up.rvalid & up.rready) != 2'b00) busy = 1'b0;
        if (g) begin
            busy = 1'b1;
            last_grant = w;
            grants.push_back(w);
            if (wk) begin
                dq.push_back('{1'b1, wa[w], wd[w]});
                wr_pend[w] = 1'b0;
            end else begin
                dq.push_back('{1'b0, ra[w], '0});
                if (w) rq1.push_back(rhash(ra[w]));
                else rq0.push_back(rhash(ra[w]));
                rd_pend[w] = 1'b0;
            end
        end
    endtask

    task automatic step();
        int unsigned k;
        @(posedge clk);
        #1;
        if (gen_en) begin
            for (int i = 0; i < 2; i++) begin
                if (!wr_pend[i] && !rd_pend[i] && $urandom_range(0, 99) < req_pct) begin
                    k = rd_only ? 1 : $urandom_range(0, 2);
                    if (k != 1) begin
                        wr_pend[i] = 1'b1;
                        wa[i] = AW'($urandom);
                        wd[i] = DW'($urandom);
                    end
                    if (k != 0) begin
                        rd_pend[i] = 1'b1;
                        ra[i] = AW'($urandom);
                    end
                end
            end
        end
        drive();
        for (int i = 0; i < 2; i++) up.rready[i] = ($urandom_range(0, 99) < rready_pct);
        @(negedge clk);
        observe();
    endtask

    task automatic drain();
        int n;
        gen_en = 1'b0;
        rd_only = 1'b0;
        rready_pct = 100;
        n = 0;
        while ((busy || dq.size() != 0 || rq0.size() != 0 || rq1.size() != 0 ||
                wr_pend != 2'b00 || rd_pend != 2'b00) && n < 300) begin
            step();
            n++;
        end
        check("drain_done", 64'(n < 300), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_awready"}, 64'(up.awready), 64'(0));
        check({tag, "_s_wready"}, 64'(up.wready), 64'(0));
        check({tag, "_s_arready"}, 64'(up.arready), 64'(0));
        check({tag, "_s_rvalid"}, 64'(up.rvalid), 64'(0));
        check({tag, "_s_rdata"}, 64'(up.rdata), 64'(0));
        check({tag, "_m_valids"}, 64'({dn.awvalid, dn.wvalid, dn.arvalid}), 64'(0));
        check({tag, "_m_rready"}, 64'(dn.rready), 64'(0));
        check({tag, "_m_awaddr"}, 64'(dn.awaddr), 64'(0));
        check({tag, "_m_araddr"}, 64'(dn.araddr), 64'(0));
        check({tag, "_m_wdata"}, 64'(dn.wdata), 64'(0));
    endtask

    // controller model: random readies, read data returned a few cycles after ar
    initial begin : controller
        bit            pend;
        int            cnt;
        logic [AW-1:0] paddr;
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        dn.awready = 1'b0;
        dn.wready = 1'b0;
        dn.arready = 1'b0;
        dn.rvalid = 1'b0;
        dn.rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            dn.awready[0] = ($urandom_range(0, 99) < rdy_pct);
            dn.wready[0]  = ($urandom_range(0, 99) < rdy_pct);
            dn.arready[0] = ($urandom_range(0, 99) < rdy_pct);
            if (aw_stall > 0) begin
                dn.awready = 1'b0;
                aw_stall--;
            end
            dn.rvalid = 1'b0;
            if (force_stray) begin
                dn.rvalid = 1'b1;
                dn.rdata = 16'hDEAD;
                force_stray = 1'b0;
            end else if (pend && !ctrl_hold) begin
                if (cnt == 0) begin
                    dn.rvalid = 1'b1;
                    dn.rdata = rhash(paddr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (!pend && stray_en && $urandom_range(0, 9) == 0) begin
                dn.rvalid = 1'b1;
                dn.rdata = DW'($urandom);
            end
            @(negedge clk);
            if (!resetn) begin
                pend = 1'b0;
            end else if (dn.arvalid[0] && dn.arready[0]) begin
                pend = 1'b1;
                cnt = $urandom_range(0, 3);
                paddr = dn.araddr;
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT completes a handshake
    initial begin : monitor
        dn_item_t      e;
        logic [DW-1:0] er;
        bit            p_awv, p_arv;
        logic [1:0]    p_rv;
        logic [AW-1:0] p_aw, p_ar;
        logic [DW-1:0] p_wd, p_rd;
        int            cap_cyc;
        p_awv = 1'b0;
        p_arv = 1'b0;
        p_rv = '0;
        p_aw = '0;
        p_ar = '0;
        p_wd = '0;
        p_rd = '0;
        cap_cyc = -10;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                p_awv = 1'b0;
                p_arv = 1'b0;
                p_rv = '0;
                cap_cyc = -10;
            end else begin
                if (p_awv) begin
                    check("stall_awvalid_held", 64'(dn.awvalid), 64'(1));
                    check("stall_awaddr_stable", 64'(dn.awaddr), 64'(p_aw));
                    check("stall_wdata_stable", 64'(dn.wdata), 64'(p_wd));
                end
                if (p_arv) begin
                    check("stall_arvalid_held", 64'(dn.arvalid), 64'(1));
                    check("stall_araddr_stable", 64'(dn.araddr), 64'(p_ar));
                end
                if (p_rv != 2'b00) begin
                    check("resp_rvalid_held", 64'(up.rvalid), 64'(p_rv));
                    check("resp_rdata_stable", 64'(up.rdata), 64'(p_rd));
                end else if (up.rvalid != 2'b00) begin
                    check("resp_latency", 64'(cyc), 64'(cap_cyc + 1));
                end
                check("resp_onehot", 64'($countones(up.rvalid) <= 1), 64'(1));
                if (dn.awvalid[0]) check("issue_wvalid_pair", 64'(dn.wvalid), 64'(1));
                if (dn.awvalid[0] && dn.awready[0] && dn.wready[0]) begin
                    wr_hs_cyc = cyc;
                    if (dq.size() == 0) fail_now("dn_extra_write");
                    else begin
                        e = dq.pop_front();
                        check("dn_write_kind", 64'(e.wr), 64'(1));
                        check("dn_write_addr", 64'(dn.awaddr), 64'(e.addr));
                        check("dn_write_data", 64'(dn.wdata), 64'(e.data));
                    end
                end
                if (dn.arvalid[0] && dn.arready[0]) begin
                    if (dq.size() == 0) fail_now("dn_extra_read");
                    else begin
                        e = dq.pop_front();
                        check("dn_read_kind", 64'(e.wr), 64'(0));
                        check("dn_read_addr", 64'(dn.araddr), 64'(e.addr));
                    end
                end
                if (dn.rvalid[0] && dn.rready[0]) cap_cyc = cyc;
                for (int i = 0; i < 2; i++) begin
                    if (up.rvalid[i] && up.rready[i]) begin
                        if ((i == 0 && rq0.size() == 0) || (i == 1 && rq1.size() == 0)) begin
                            fail_now("up_extra_response");
                        end else begin
                            er = (i == 0) ? rq0.pop_front() : rq1.pop_front();
                            check("up_read_data", 64'(up.rdata), 64'(er));
                        end
                    end
                end
                p_awv = dn.awvalid[0] && !(dn.awready[0] && dn.wready[0]);
                p_arv = dn.arvalid[0] && !dn.arready[0];
                p_rv  = up.rvalid & ~up.rready;
                p_aw  = dn.awaddr;
                p_ar  = dn.araddr;
                p_wd  = dn.wdata;
                p_rd  = up.rdata;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  gc;
        int  base;
        bit  lg0;
        for (int i = 0; i < 2; i++) begin
            wa[i] = '0;
            wd[i] = '0;
            ra[i] = '0;
        end
        up.awvalid = 2'b11;
        up.wvalid = 2'b11;
        up.arvalid = 2'b11;
        up.awaddr = '1;
        up.araddr = '1;
        up.wdata = '1;
        up.rready = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        drive();
        @(posedge clk);
        #2;
        resetn = 1'b1;

        // single write from port 0, controller always ready
        wr_pend[0] = 1'b1;
        wa[0] = 25'h0001234;
        wd[0] = 16'hBEEF;
        step();
        check("t1_accept_c0", 64'(up.awready & up.wready), 64'(2'b01));
        step();
        check("t1_valids_c1", 64'({dn.awvalid, dn.wvalid}), 64'(2'b11));
        check("t1_awaddr_c1", 64'(dn.awaddr), 64'(25'h0001234));
        check("t1_wdata_c1", 64'(dn.wdata), 64'(16'hBEEF));
        check("t1_no_up_ready_c1", 64'({up.awready, up.arready}), 64'(0));
        wr_pend[1] = 1'b1;
        wa[1] = AW'($urandom);
        wd[1] = DW'($urandom);
        step();
        check("t1_next_accept_c2", 64'(up.awready), 64'(2'b10));
        drain();

        // port 0 holds write and read: write first, read on the next idle cycle
        wr_pend[0] = 1'b1;
        rd_pend[0] = 1'b1;
        wa[0] = AW'($urandom);
        wd[0] = DW'($urandom);
        ra[0] = AW'($urandom);
        step();
        check("t4_write_first", 64'({up.awready, up.arready}), 64'(4'b0100));
        step();
        step();
        check("t4_read_next", 64'({up.awready, up.arready}), 64'(4'b0001));
        drain();

        // downstream write stalled by m_awready for five issue cycles
        aw_stall = 6;
        wr_pend[0] = 1'b1;
        wa[0] = AW'($urandom);
        wd[0] = DW'($urandom);
        step();
        gc = cyc;
        repeat (6) step();
        #1;
        check("stall_done_c6", 64'(wr_hs_cyc - gc), 64'(6));
        drain();

        // randomized traffic
        gen_en = 1'b1;
        req_pct = 40;
        rdy_pct = 60;
        rready_pct = 60;
        stray_en = 1'b1;
        repeat (1500) step();
        drain();
        stray_en = 1'b0;
        rdy_pct = 100;

        // both ports issue reads continuously
        base = grants.size();
        lg0 = last_grant;
        gen_en = 1'b1;
        rd_only = 1'b1;
        req_pct = 100;
        rready_pct = 100;
        repeat (40) step();
        check("b2b_grant_count", 64'(grants.size() - base >= 4), 64'(1));
        if (grants.size() - base >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check("b2b_grant_order", 64'(grants[base + k]),
                      64'(RR ? ((k % 2 == 0) ? !lg0 : lg0) : 1'b0));
            end
        end
        drain();

        // reset while waiting for read data, then a stray m_rvalid
        ctrl_hold = 1'b1;
        rd_pend[1] = 1'b1;
        ra[1] = 25'h1FFFFFF;
        repeat (4) step();
        check("rst_in_wait_r", 64'(dn.rready), 64'(1));
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        busy = 1'b0;
        last_grant = 1'b1;
        dq.delete();
        rq0.delete();
        rq1.delete();
        wr_pend = '0;
        rd_pend = '0;
        ctrl_hold = 1'b0;
        repeat (2) step();
        @(posedge clk);
        #2;
        resetn = 1'b1;
        force_stray = 1'b1;
        repeat (3) begin
            step();
            check("rst_no_rvalid", 64'(up.rvalid), 64'(0));
            check("rst_no_capture", 64'(up.rdata), 64'(0));
        end
        wr_pend[0] = 1'b1;
        wa[0] = AW'($urandom);
        wd[0] = DW'($urandom);
        rd_pend[1] = 1'b1;
        ra[1] = AW'($urandom);
        step();
        check("rst_first_grant_p0", 64'(up.awready | up.arready), 64'(2'b01));
        drain();

        check("end_queues_empty", 64'(dq.size() + rq0.size() + rq1.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
